// File: rtl/regfile_mp_sb_pkg.sv
// Shared defaults, index/word types and index helpers for the multi-port
// register file with busy scoreboard.
package regfile_pkg;

  localparam int REGFILE_ADDR_WIDTH = 5;
  localparam int REGFILE_WORD_LEN   = 32;
  localparam int REGFILE_NUM_RPORTS = 2;
  localparam int REG_IDX_MAX_W      = 8;

  typedef logic [REGFILE_ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [REGFILE_WORD_LEN-1:0]   word_t;

  // Callers zero-extend their index, so one helper covers any width up to 8 bits.
  function automatic logic is_zero_idx(input logic [REG_IDX_MAX_W-1:0] idx);
    return (idx == '0);
  endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback-facing bus of the register file; master is the core side,
// slave is the register file.
interface regfile_mp_sb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_LEN   = 32,
  parameter int NUM_RPORTS = 2
);

  logic [NUM_RPORTS*ADDR_WIDTH-1:0]    raddr;
  logic [NUM_RPORTS*WORD_LEN-1:0]      rdata;
  logic [NUM_RPORTS-1:0]               rbusy;
  logic                                wen;
  logic [ADDR_WIDTH-1:0]               waddr;
  logic [WORD_LEN-1:0]                 wdata;
  logic                                issue_valid;
  logic [ADDR_WIDTH-1:0]               issue_rd;
  logic                                issue_ready;
  logic                                flush;
  logic [(2**ADDR_WIDTH)*WORD_LEN-1:0] signal_rf;

  modport master (
    output raddr, wen, waddr, wdata, issue_valid, issue_rd, flush,
    input  rdata, rbusy, issue_ready, signal_rf
  );

  modport slave (
    input  raddr, wen, waddr, wdata, issue_valid, issue_rd, flush,
    output rdata, rbusy, issue_ready, signal_rf
  );

endinterface

// File: rtl/regfile_mp_sb_read_port.sv
// One registered read port: selects zero, same-cycle write bypass or array
// contents, and holds the rdata/rbusy output flops.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
  parameter int WORD_LEN   = REGFILE_WORD_LEN,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic [WORD_LEN-1:0]   rf_word_i,
  input  logic                  busy_i,
  input  logic                  wen_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WORD_LEN-1:0]   wdata_i,
  input  logic                  issue_acc_i,
  input  logic [ADDR_WIDTH-1:0] issue_rd_i,
  output logic [WORD_LEN-1:0]   rdata_o,
  output logic                  rbusy_o
);

  logic [WORD_LEN-1:0] rdata_d, rdata_q;
  logic                rbusy_d, rbusy_q;
  logic                hit;
  logic                zero_rd;

  always_comb begin
    hit     = wen_i && (waddr_i == raddr_i);
    zero_rd = ZERO_REG && is_zero_idx(REG_IDX_MAX_W'(raddr_i));
    rdata_d = rf_word_i;
    rbusy_d = busy_i;
    if (zero_rd) begin
      rdata_d = '0;
      rbusy_d = 1'b0;
    end else if (BYPASS && hit) begin
      // A same-cycle accepted issue to this register re-arms busy.
      rdata_d = wdata_i;
      rbusy_d = issue_acc_i && (issue_rd_i == raddr_i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
      rbusy_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rbusy_q <= rbusy_d;
    end
  end

  assign rdata_o = rdata_q;
  assign rbusy_o = rbusy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with hardwired-zero x0, write-first bypass
// and a per-register busy scoreboard for in-flight destinations.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
  parameter int WORD_LEN   = REGFILE_WORD_LEN,
  parameter int NUM_RPORTS = REGFILE_NUM_RPORTS,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input logic           clk,
  input logic           reset_n,
  regfile_mp_sb_if.slave bus
);

  localparam int NREGS = 2**ADDR_WIDTH;

  logic [WORD_LEN-1:0] rf_q [NREGS];
  logic [WORD_LEN-1:0] rf_d [NREGS];
  logic [NREGS-1:0]    busy_q, busy_d;
  logic                wr_eff;
  logic                issue_zero;
  logic                issue_acc;

  logic [WORD_LEN-1:0] rdata_arr [NUM_RPORTS];
  logic                rbusy_arr [NUM_RPORTS];

  always_comb begin
    wr_eff          = bus.wen && !(ZERO_REG && is_zero_idx(REG_IDX_MAX_W'(bus.waddr)));
    issue_zero      = ZERO_REG && is_zero_idx(REG_IDX_MAX_W'(bus.issue_rd));
    bus.issue_ready = issue_zero || !busy_q[bus.issue_rd] ||
                      (bus.wen && (bus.waddr == bus.issue_rd));
    // x0 issues are accepted for handshake purposes but never mark busy.
    issue_acc       = bus.issue_valid && bus.issue_ready && !bus.flush && !issue_zero;
  end

  always_comb begin
    rf_d   = rf_q;
    busy_d = busy_q;
    if (wr_eff) rf_d[bus.waddr] = bus.wdata;
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      if (wr_eff)    busy_d[bus.waddr]    = 1'b0;
      if (issue_acc) busy_d[bus.issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      busy_q <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
    end
  end

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
    logic [ADDR_WIDTH-1:0] ra;
    assign ra = bus.raddr[p*ADDR_WIDTH +: ADDR_WIDTH];

    regfile_read_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WORD_LEN   (WORD_LEN),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_port (
      .clk         (clk),
      .reset_n     (reset_n),
      .raddr_i     (ra),
      .rf_word_i   (rf_q[ra]),
      .busy_i      (busy_q[ra]),
      .wen_i       (bus.wen),
      .waddr_i     (bus.waddr),
      .wdata_i     (bus.wdata),
      .issue_acc_i (issue_acc),
      .issue_rd_i  (bus.issue_rd),
      .rdata_o     (rdata_arr[p]),
      .rbusy_o     (rbusy_arr[p])
    );
  end

  always_comb begin
    bus.rdata     = '0;
    bus.rbusy     = '0;
    bus.signal_rf = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      bus.rdata[p*WORD_LEN +: WORD_LEN] = rdata_arr[p];
      bus.rbusy[p]                      = rbusy_arr[p];
    end
    for (int i = 0; i < NREGS; i++) bus.signal_rf[i*WORD_LEN +: WORD_LEN] = rf_q[i];
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: one DUT with bypass, one without, driven
// by the same stimulus.
module tb_regfile_mp_sb;
  import regfile_pkg::*;

  logic clk;
  logic reset_n;

  logic [9:0]  t_raddr;
  logic        t_wen;
  logic [4:0]  t_waddr;
  logic [31:0] t_wdata;
  logic        t_issue_valid;
  logic [4:0]  t_issue_rd;
  logic        t_flush;

  int checks = 0;
  int errors = 0;

  regfile_mp_sb_if #(.ADDR_WIDTH(5), .WORD_LEN(32), .NUM_RPORTS(2)) bus0 ();
  regfile_mp_sb_if #(.ADDR_WIDTH(5), .WORD_LEN(32), .NUM_RPORTS(2)) bus1 ();

  assign bus0.raddr = t_raddr;        assign bus1.raddr = t_raddr;
  assign bus0.wen = t_wen;            assign bus1.wen = t_wen;
  assign bus0.waddr = t_waddr;        assign bus1.waddr = t_waddr;
  assign bus0.wdata = t_wdata;        assign bus1.wdata = t_wdata;
  assign bus0.issue_valid = t_issue_valid; assign bus1.issue_valid = t_issue_valid;
  assign bus0.issue_rd = t_issue_rd;  assign bus1.issue_rd = t_issue_rd;
  assign bus0.flush = t_flush;        assign bus1.flush = t_flush;

  regfile_mp_sb #(.ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_byp (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  regfile_mp_sb #(.ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nobyp (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    t_raddr       = '0;
    t_wen         = 1'b0;
    t_waddr       = '0;
    t_wdata       = '0;
    t_issue_valid = 1'b0;
    t_issue_rd    = '0;
    t_flush       = 1'b0;
    step();
    step();
    chk("rst_rdata",  bus0.rdata[31:0], 32'h0);
    chk("rst_rbusy",  {30'b0, bus0.rbusy}, 32'h0);
    chk("rst_rf_any", {31'b0, |bus0.signal_rf}, 32'h0);

    reset_n = 1'b1;
    t_raddr = {5'd5, 5'd0};
    step();
    chk("post_rst_rdata0", bus0.rdata[31:0], 32'h0);
    chk("post_rst_rdata1", bus0.rdata[63:32], 32'h0);
    chk("post_rst_rbusy",  {30'b0, bus0.rbusy}, 32'h0);
    chk("post_rst_rf_any", {31'b0, |bus0.signal_rf}, 32'h0);
    chk("post_rst_ready",  {31'b0, bus0.issue_ready}, 32'h1);

    // Write x5 while port 1 reads x5 in the same cycle.
    t_wen = 1'b1; t_waddr = 5'd5; t_wdata = 32'hDEADBEEF;
    step();
    chk("wr5_byp_port1",   bus0.rdata[63:32], 32'hDEADBEEF);
    chk("wr5_nobyp_port1", bus1.rdata[63:32], 32'h0);
    t_wen = 1'b0;
    t_raddr = {5'd5, 5'd5};
    step();
    chk("rd5_byp",   bus0.rdata[31:0], 32'hDEADBEEF);
    chk("rd5_nobyp", bus1.rdata[31:0], 32'hDEADBEEF);
    chk("rd5_busy",  {30'b0, bus0.rbusy}, 32'h0);
    chk("rf5",       bus0.signal_rf[5*32 +: 32], 32'hDEADBEEF);

    t_wen = 1'b1; t_waddr = 5'd7; t_wdata = 32'h1234;
    t_raddr = {5'd7, 5'd5};
    step();
    chk("byp7_port1",   bus0.rdata[63:32], 32'h1234);
    chk("nobyp7_port1", bus1.rdata[63:32], 32'h0);
    chk("byp7_rbusy1",  {31'b0, bus0.rbusy[1]}, 32'h0);
    chk("byp7_port0",   bus0.rdata[31:0], 32'hDEADBEEF);
    t_wen = 1'b0;
    step();
    chk("nobyp7_later", bus1.rdata[63:32], 32'h1234);

    t_wen = 1'b1; t_waddr = 5'd0; t_wdata = 32'hFFFFFFFF;
    t_issue_valid = 1'b1; t_issue_rd = 5'd0;
    t_raddr = {5'd0, 5'd0};
    #1;
    chk("x0_ready", {31'b0, bus0.issue_ready}, 32'h1);
    step();
    t_wen = 1'b0; t_issue_valid = 1'b0;
    chk("x0_byp_rdata0", bus0.rdata[31:0], 32'h0);
    chk("x0_byp_rdata1", bus0.rdata[63:32], 32'h0);
    chk("x0_byp_rbusy",  {30'b0, bus0.rbusy}, 32'h0);
    chk("x0_nobyp_rd0",  bus1.rdata[31:0], 32'h0);
    step();
    chk("x0_rf0",        bus0.signal_rf[31:0], 32'h0);
    chk("x0_rbusy_late", {30'b0, bus0.rbusy}, 32'h0);
    chk("x0_ready_late", {31'b0, bus0.issue_ready}, 32'h1);

    t_issue_valid = 1'b1; t_issue_rd = 5'd3;
    t_raddr = {5'd0, 5'd3};
    #1;
    chk("iss3_ready_free", {31'b0, bus0.issue_ready}, 32'h1);
    step();
    t_issue_valid = 1'b0;
    chk("iss3_rbusy_pre", {31'b0, bus0.rbusy[0]}, 32'h0);
    #1;
    chk("iss3_ready_busy", {31'b0, bus0.issue_ready}, 32'h0);
    step();
    chk("iss3_rbusy_byp",   {31'b0, bus0.rbusy[0]}, 32'h1);
    chk("iss3_rbusy_nobyp", {31'b0, bus1.rbusy[0]}, 32'h1);

    // Writeback of x3 racing a new producer for x3: data lands, busy stays set.
    t_wen = 1'b1; t_waddr = 5'd3; t_wdata = 32'h55;
    t_issue_valid = 1'b1; t_issue_rd = 5'd3;
    #1;
    chk("wi3_ready", {31'b0, bus0.issue_ready}, 32'h1);
    step();
    t_wen = 1'b0; t_issue_valid = 1'b0;
    chk("wi3_byp_rdata",   bus0.rdata[31:0], 32'h55);
    chk("wi3_byp_rbusy",   {31'b0, bus0.rbusy[0]}, 32'h1);
    chk("wi3_nobyp_rdata", bus1.rdata[31:0], 32'h0);
    chk("wi3_nobyp_rbusy", {31'b0, bus1.rbusy[0]}, 32'h1);
    step();
    chk("wi3_rdata_late", bus1.rdata[31:0], 32'h55);
    chk("wi3_rbusy_late", {31'b0, bus0.rbusy[0]}, 32'h1);
    chk("wi3_ready_late", {31'b0, bus0.issue_ready}, 32'h0);

    t_flush = 1'b1; t_issue_valid = 1'b1; t_issue_rd = 5'd6;
    t_wen = 1'b1; t_waddr = 5'd3; t_wdata = 32'h66;
    t_raddr = {5'd6, 5'd3};
    step();
    t_flush = 1'b0; t_issue_valid = 1'b0; t_wen = 1'b0;
    chk("fl_byp_rdata",   bus0.rdata[31:0], 32'h66);
    chk("fl_byp_rbusy",   {31'b0, bus0.rbusy[0]}, 32'h0);
    chk("fl_nobyp_rdata", bus1.rdata[31:0], 32'h55);
    chk("fl_nobyp_rbusy", {31'b0, bus1.rbusy[0]}, 32'h1);
    step();
    chk("fl_rbusy_byp",   {30'b0, bus0.rbusy}, 32'h0);
    chk("fl_rbusy_nobyp", {30'b0, bus1.rbusy}, 32'h0);
    chk("fl_rdata_nobyp", bus1.rdata[31:0], 32'h66);
    chk("fl_ready6",      {31'b0, bus0.issue_ready}, 32'h1);
    t_issue_rd = 5'd3;
    #1;
    chk("fl_ready3", {31'b0, bus0.issue_ready}, 32'h1);

    t_wen = 1'b1; t_waddr = 5'd9; t_wdata = 32'hABCD;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_rdata0", bus0.rdata[31:0], 32'h0);
    chk("arst_rdata1", bus1.rdata[31:0], 32'h0);
    chk("arst_rbusy",  {30'b0, bus0.rbusy}, 32'h0);
    chk("arst_rf3",    bus0.signal_rf[3*32 +: 32], 32'h0);
    t_wen = 1'b0;
    step();
    step();
    chk("arst_rf9",    bus0.signal_rf[9*32 +: 32], 32'h0);
    chk("arst_rf_any", {31'b0, |bus0.signal_rf}, 32'h0);
    reset_n = 1'b1;
    step();
    chk("arst_rf9_after", bus0.signal_rf[9*32 +: 32], 32'h0);
    chk("arst_rf5_after", bus0.signal_rf[5*32 +: 32], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
